// File: rtl/core_run_ctrl.sv
// core_run_ctrl: reset sequencer and run watchdog for N_CHAN processor cores.
// Holds core resets, releases them staggered, then ends the run on all-halted or cycle budget.
module core_run_ctrl #(
    parameter int N_CHAN     = 1,
    parameter int RST_CYCLES = 5,
    parameter int STAGGER    = 0,
    parameter int RUN_CYCLES = 216,
    parameter int CNT_WIDTH  = 16,
    parameter int AUTO_START = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic [N_CHAN-1:0]    i_halt,
    output logic [N_CHAN-1:0]    o_core_rst,
    output logic                 o_running,
    output logic                 o_done,
    output logic                 o_timeout,
    output logic [CNT_WIDTH-1:0] o_cycles,
    output logic [N_CHAN-1:0]    o_halted
);
    typedef enum logic [1:0] {IDLE, HOLD, RUN, FINISH} state_t;
    state_t state, state_nx;
    logic [CNT_WIDTH-1:0] rel_cnt;
    logic [N_CHAN-1:0] halt_q, rel_hit;
    logic all_halted, time_up, enter_hold, finishing;
    always_comb begin
        halt_q     = o_halted | (i_halt & ~o_core_rst);
        all_halted = &halt_q;
        time_up    = (RUN_CYCLES != 0) && (o_cycles == CNT_WIDTH'(RUN_CYCLES - 1));
        for (int k = 0; k < N_CHAN; k++)
            rel_hit[k] = rel_cnt == CNT_WIDTH'(RST_CYCLES - 1 + k * STAGGER);
        state_nx = state;
        unique case (state)
            IDLE:   state_nx = (AUTO_START != 0 || i_start) ? HOLD : IDLE;
            HOLD:   state_nx = rel_hit[0] ? RUN : HOLD;
            RUN:    state_nx = (all_halted || time_up) ? FINISH : RUN;
            FINISH: state_nx = i_start ? HOLD : FINISH;
        endcase
        enter_hold = (state_nx == HOLD) && (state != HOLD);
        finishing  = (state == RUN) && (state_nx == FINISH);
    end
    assign o_running = state == RUN;
    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nx;
    end
    always_ff @(posedge i_clk) begin
        if (i_rst || enter_hold) begin
            o_core_rst <= '1;
            o_cycles   <= '0;
            o_halted   <= '0;
            o_done     <= 1'b0;
            o_timeout  <= 1'b0;
            rel_cnt    <= '0;
        end else if (state == HOLD || state == RUN) begin
            rel_cnt    <= (&rel_cnt) ? rel_cnt : rel_cnt + 1'b1;
            o_core_rst <= finishing ? '1 : (o_core_rst & ~rel_hit);
            if (state == RUN) begin
                o_halted  <= halt_q;
                o_cycles  <= (finishing || &o_cycles) ? o_cycles : o_cycles + 1'b1;
                // done has priority when the last halt lands on the budget cycle
                o_done    <= finishing && all_halted;
                o_timeout <= finishing && !all_halted;
            end
        end
    end
endmodule

// File: tb/tb_core_run_ctrl.sv
// tb_core_run_ctrl: directed checks of three core_run_ctrl configurations.
module tb_core_run_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    int n_run = 0;
    int n_fail = 0;

    logic rst0 = 1'b1, start0 = 1'b0;
    logic [0:0] halt0 = '0, crst0, hlt0;
    logic run0, done0, tmo0;
    logic [15:0] cyc0;
    core_run_ctrl u0 (
        .i_clk(clk), .i_rst(rst0), .i_start(start0), .i_halt(halt0),
        .o_core_rst(crst0), .o_running(run0), .o_done(done0),
        .o_timeout(tmo0), .o_cycles(cyc0), .o_halted(hlt0)
    );

    logic rst1 = 1'b1, start1 = 1'b0;
    logic [2:0] halt1 = '0, crst1, hlt1;
    logic run1, done1, tmo1;
    logic [15:0] cyc1;
    core_run_ctrl #(.N_CHAN(3), .STAGGER(4), .RUN_CYCLES(30), .AUTO_START(0)) u1 (
        .i_clk(clk), .i_rst(rst1), .i_start(start1), .i_halt(halt1),
        .o_core_rst(crst1), .o_running(run1), .o_done(done1),
        .o_timeout(tmo1), .o_cycles(cyc1), .o_halted(hlt1)
    );

    logic rst2 = 1'b1, start2 = 1'b0;
    logic [1:0] halt2 = '0, crst2, hlt2;
    logic run2, done2, tmo2;
    logic [15:0] cyc2;
    core_run_ctrl #(.N_CHAN(2), .RUN_CYCLES(50)) u2 (
        .i_clk(clk), .i_rst(rst2), .i_start(start2), .i_halt(halt2),
        .o_core_rst(crst2), .o_running(run2), .o_done(done2),
        .o_timeout(tmo2), .o_cycles(cyc2), .o_halted(hlt2)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        tick(5);
        check("rst0_core_rst", crst0, 1);
        check("rst0_running", run0, 0);
        check("rst0_flags", {done0, tmo0}, 0);
        check("rst0_cycles", cyc0, 0);
        check("rst0_halted", hlt0, 0);
        check("rst1_core_rst", crst1, 7);
        check("rst2_core_rst", crst2, 3);

        // defaults: release after 5 held cycles, timeout after 216 run cycles
        rst0 = 1'b0;
        tick(5);
        check("d_held", crst0, 1);
        check("d_not_running", run0, 0);
        tick(1);
        check("d_released", crst0, 0);
        check("d_running", run0, 1);
        check("d_cyc0", cyc0, 0);
        tick(215);
        check("d_cyc215", cyc0, 215);
        check("d_no_tmo_yet", tmo0, 0);
        tick(1);
        check("d_timeout", tmo0, 1);
        check("d_not_done", done0, 0);
        check("d_cyc_frozen", cyc0, 215);
        check("d_rst_reheld", crst0, 1);
        check("d_stopped", run0, 0);
        tick(3);
        check("d_finish_stays", {run0, tmo0, cyc0}, {1'b0, 1'b1, 16'd215});

        // restart from FINISH, start ignored while running
        start0 = 1'b1;
        tick(1);
        start0 = 1'b0;
        check("r_cleared", {tmo0, done0, cyc0}, 0);
        check("r_held", crst0, 1);
        tick(4);
        check("r_still_held", crst0, 1);
        tick(1);
        check("r_released", {crst0, run0}, 2'b01);
        start0 = 1'b1;
        tick(1);
        start0 = 1'b0;
        check("r_start_ignored", {run0, crst0, cyc0}, {1'b1, 1'b0, 16'd1});

        // staggered release, AUTO_START=0
        rst1 = 1'b0;
        tick(3);
        check("s_idle_wait", {run1, crst1}, 4'b0111);
        start1 = 1'b1;
        tick(1);
        start1 = 1'b0;
        tick(4);
        check("s_hold5", crst1, 7);
        tick(1);
        check("s_rel0", crst1, 6);
        check("s_run", run1, 1);
        tick(3);
        check("s_hold9", crst1, 6);
        tick(1);
        check("s_rel1", crst1, 4);
        halt1 = 3'b100;
        tick(1);
        halt1 = 3'b000;
        check("s_halt_in_rst_ignored", hlt1, 0);
        tick(2);
        check("s_hold13", crst1, 4);
        tick(1);
        check("s_rel2", crst1, 0);
        check("s_cyc8", cyc1, 8);
        tick(21);
        check("s_cyc29", cyc1, 29);
        halt1 = 3'b111;
        tick(1);
        halt1 = 3'b000;
        check("s_done_wins", done1, 1);
        check("s_no_timeout", tmo1, 0);
        check("s_halted_all", hlt1, 7);
        check("s_cyc_frozen", cyc1, 29);
        check("s_rst_reheld", {run1, crst1}, 4'b0111);

        // mid-run reset
        start1 = 1'b1;
        tick(1);
        start1 = 1'b0;
        check("m_cleared", {done1, tmo1, hlt1, cyc1}, 0);
        tick(5);
        halt1 = 3'b001;
        tick(7);
        check("m_cyc7", cyc1, 7);
        check("m_halted0", hlt1, 1);
        rst1 = 1'b1;
        tick(1);
        rst1 = 1'b0;
        halt1 = 3'b000;
        check("m_rst_core", crst1, 7);
        check("m_rst_outs", {run1, done1, tmo1, hlt1, cyc1}, 0);
        tick(3);
        check("m_stays_idle", {run1, crst1}, 4'b0111);

        // two channels finish by halting
        rst2 = 1'b0;
        tick(6);
        check("h_running", {run2, crst2}, 3'b100);
        tick(10);
        check("h_cyc10", cyc2, 10);
        halt2 = 2'b01;
        tick(1);
        halt2 = 2'b00;
        check("h_halted0", {hlt2, done2}, 3'b010);
        tick(9);
        check("h_cyc20", cyc2, 20);
        halt2 = 2'b10;
        tick(1);
        halt2 = 2'b00;
        check("h_done", {done2, tmo2}, 2'b10);
        check("h_cyc_frozen", cyc2, 20);
        check("h_halted_all", hlt2, 3);
        check("h_rst_reheld", {run2, crst2}, 3'b011);
        tick(3);
        check("h_no_auto_restart", {run2, done2, cyc2}, {1'b0, 1'b1, 16'd20});

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
